// File: rtl/ifetch_queue.sv
// Instruction fetch stage with a DEPTH-entry in-order queue between the icache and decode.
// Optional combinational response-to-decode forwarding is enabled by defining IFQ_BYPASS_EN.
module ifetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [XLEN-1:0]            reset_adr_i,
  output logic                       icache_req_o,
  output logic [XLEN-1:0]            icache_adr_o,
  input  logic                       icache_gnt_i,
  input  logic                       icache_rsp_v_i,
  input  logic [31:0]                icache_instr_i,
  input  logic                       flush_v_q_i,
  input  logic [XLEN-1:0]            pc_data_q_i,
  output logic                       dec_v_o,
  input  logic                       dec_ready_i,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end

  state_e               state_q, state_d;
  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]      alloc_q, alloc_d;
  logic [PtrW-1:0]      fill_q, fill_d;
  logic [PtrW-1:0]      read_q, read_d;
  logic [PtrW-1:0]      drop_cnt_q, drop_cnt_d;

  logic [XLEN-1:0]      pc_mem_q    [DEPTH];
  logic [31:0]          instr_mem_q [DEPTH];
  logic [DEPTH-1:0]     filled_q;

  logic [PtrW-1:0]      occupancy;
  logic [PtrW-1:0]      outstanding;
  logic                 full;
  logic                 grant;
  logic                 rsp_keep;
  logic                 byp;
  logic                 pop;
  logic [IdxW-1:0]      head_idx;
  logic [IdxW-1:0]      fill_idx;
  logic [IdxW-1:0]      alloc_idx;

  assign occupancy   = alloc_q - read_q;
  assign outstanding = alloc_q - fill_q;
  assign full        = (occupancy == PtrW'(DEPTH));
  assign head_idx    = read_q[IdxW-1:0];
  assign fill_idx    = fill_q[IdxW-1:0];
  assign alloc_idx   = alloc_q[IdxW-1:0];

  always_comb begin
    icache_req_o = reset_n && (state_q == StRun) && !flush_v_q_i && !full;
    icache_adr_o = fetch_pc_q;
    grant        = icache_req_o && icache_gnt_i;
    // Responses in DRAIN or in the flush cycle belong to a squashed stream.
    rsp_keep     = (state_q == StRun) && !flush_v_q_i && icache_rsp_v_i && (outstanding != '0);
`ifdef IFQ_BYPASS_EN
    byp          = rsp_keep && (fill_q == read_q);
`else
    byp          = 1'b0;
`endif
    dec_v_o      = !flush_v_q_i && (filled_q[head_idx] || byp);
    instr_o      = byp ? icache_instr_i : instr_mem_q[head_idx];
    pc_o         = pc_mem_q[head_idx];
    pop          = dec_v_o && dec_ready_i;
    occupancy_o  = occupancy;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = grant ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    alloc_d    = alloc_q + PtrW'(grant);
    fill_d     = fill_q + PtrW'(rsp_keep);
    read_d     = read_q + PtrW'(pop);
    drop_cnt_d = drop_cnt_q;

    if (state_q == StDrain && icache_rsp_v_i) begin
      drop_cnt_d = drop_cnt_q - PtrW'(1);
      if (drop_cnt_q == PtrW'(1)) begin
        state_d = StRun;
      end
    end

    if (flush_v_q_i) begin
      alloc_d    = '0;
      fill_d     = '0;
      read_d     = '0;
      fetch_pc_d = pc_data_q_i & ~XLEN'(3);
      // In RUN drop_cnt is zero; in DRAIN the pointers are equal, so the sum covers both.
      drop_cnt_d = outstanding + drop_cnt_q - PtrW'(icache_rsp_v_i);
      state_d    = (drop_cnt_d != '0) ? StDrain : StRun;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StRun;
      fetch_pc_q <= reset_adr_i;
      alloc_q    <= '0;
      fill_q     <= '0;
      read_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      read_q     <= read_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (flush_v_q_i) begin
      filled_q <= '0;
    end else begin
      if (grant) begin
        pc_mem_q[alloc_idx] <= fetch_pc_q;
        filled_q[alloc_idx] <= 1'b0;
      end
      if (rsp_keep) begin
        instr_mem_q[fill_idx] <= icache_instr_i;
        // A forwarded-and-consumed response never occupies its entry.
        if (!(byp && pop)) begin
          filled_q[fill_idx] <= 1'b1;
        end
      end
      if (pop) begin
        filled_q[head_idx] <= 1'b0;
      end
    end
  end

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!reset_n)
    icache_rsp_v_i |-> (outstanding != '0) || (drop_cnt_q != '0));

  a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n)
    occupancy <= PtrW'(DEPTH));

  a_drain_idle: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StDrain) |-> (alloc_q == fill_q) && (drop_cnt_q != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed, table-driven bench for ifetch_queue: per-cycle stimulus with hand-computed outputs.
// Expectations follow IFQ_BYPASS_EN when it is defined for the build.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] reset_adr;
  logic        req;
  logic [31:0] adr;
  logic        gnt;
  logic        rsp_v;
  logic [31:0] rsp_instr;
  logic        flush;
  logic [31:0] flush_pc;
  logic        dec_v;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  occ;

  ifetch_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .reset_adr_i    (reset_adr),
    .icache_req_o   (req),
    .icache_adr_o   (adr),
    .icache_gnt_i   (gnt),
    .icache_rsp_v_i (rsp_v),
    .icache_instr_i (rsp_instr),
    .flush_v_q_i    (flush),
    .pc_data_q_i    (flush_pc),
    .dec_v_o        (dec_v),
    .dec_ready_i    (dec_ready),
    .instr_o        (instr),
    .pc_o           (pc),
    .occupancy_o    (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rsp;
    logic [31:0] rinstr;
    logic        rdy;
    logic        fl;
    logic [31:0] fpc;
    logic        ereq;
    logic [31:0] eadr;
    logic        edv;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic [2:0]  eocc;
  } vec_t;

  vec_t  vecs[$];
  string phase;
  int    n_tests;
  int    n_fail;

  function automatic vec_t mk(logic g, logic r, logic [31:0] ri, logic rd, logic f,
                              logic [31:0] fp, logic erq, logic [31:0] ea, logic edv,
                              logic [31:0] ei, logic [31:0] ep, logic [2:0] eo);
    vec_t v;
    v.gnt = g;   v.rsp = r;    v.rinstr = ri; v.rdy = rd;   v.fl = f;     v.fpc = fp;
    v.ereq = erq; v.eadr = ea; v.edv = edv;   v.einstr = ei; v.epc = ep;  v.eocc = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    gnt = 1'b0; rsp_v = 1'b0; rsp_instr = '0; flush = 1'b0; flush_pc = '0; dec_ready = 1'b0;
  endtask

  // Leaves reset released at a falling edge so the next vector starts a clean cycle.
  task automatic do_reset(input logic [31:0] radr, input string nm);
    phase = nm;
    drive_idle();
    gnt       = 1'b1;
    dec_ready = 1'b1;
    reset_adr = radr;
    reset_n   = 1'b0;
    #1;
    chk({nm, " rst req"},   32'(req),   32'd0);
    chk({nm, " rst dec_v"}, 32'(dec_v), 32'd0);
    chk({nm, " rst occ"},   32'(occ),   32'd0);
    chk({nm, " rst instr"}, instr,      32'd0);
    chk({nm, " rst pc"},    pc,         32'd0);
    repeat (2) @(negedge clk);
    drive_idle();
    reset_n = 1'b1;
    vecs.delete();
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      gnt = vecs[i].gnt;   rsp_v = vecs[i].rsp; rsp_instr = vecs[i].rinstr;
      dec_ready = vecs[i].rdy; flush = vecs[i].fl; flush_pc = vecs[i].fpc;
      #1;
      chk($sformatf("%s c%0d req", phase, i),   32'(req),   32'(vecs[i].ereq));
      chk($sformatf("%s c%0d adr", phase, i),   adr,        vecs[i].eadr);
      chk($sformatf("%s c%0d dec_v", phase, i), 32'(dec_v), 32'(vecs[i].edv));
      chk($sformatf("%s c%0d occ", phase, i),   32'(occ),   32'(vecs[i].eocc));
      if (vecs[i].edv) begin
        chk($sformatf("%s c%0d instr", phase, i), instr, vecs[i].einstr);
        chk($sformatf("%s c%0d pc", phase, i),    pc,    vecs[i].epc);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b1;
    reset_adr = '0;
    drive_idle();
    @(negedge clk);

    // Streaming: gnt every cycle, 1-cycle responses, decode always ready.
    do_reset(32'h8000_0000, "stream");
    vecs.push_back(mk(1, 0, 0,           1, 0, 0, 1, 32'h8000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h1111_0000, 1, 0, 0, 1, 32'h8000_0004, Byp,
                      32'h1111_0000, 32'h8000_0000, 1));
    vecs.push_back(mk(1, 1, 32'h1111_0001, 1, 0, 0, 1, 32'h8000_0008, 1,
                      Byp ? 32'h1111_0001 : 32'h1111_0000,
                      Byp ? 32'h8000_0004 : 32'h8000_0000, Byp ? 3'd1 : 3'd2));
    vecs.push_back(mk(1, 1, 32'h1111_0002, 1, 0, 0, 1, 32'h8000_000C, 1,
                      Byp ? 32'h1111_0002 : 32'h1111_0001,
                      Byp ? 32'h8000_0008 : 32'h8000_0004, Byp ? 3'd1 : 3'd2));
    vecs.push_back(mk(0, 1, 32'h1111_0003, 1, 0, 0, 1, 32'h8000_0010, 1,
                      Byp ? 32'h1111_0003 : 32'h1111_0002,
                      Byp ? 32'h8000_000C : 32'h8000_0008, Byp ? 3'd1 : 3'd2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h8000_0010, !Byp,
                      32'h1111_0003, 32'h8000_000C, Byp ? 3'd0 : 3'd1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h8000_0010, 0, 0, 0, 0));
    run_vecs();

    // Full queue: decode stalled, exactly DEPTH grants, then one pop frees one slot.
    do_reset(32'h0000_1000, "full");
    vecs.push_back(mk(1, 0, 0,           0, 0, 0, 1, 32'h1000, 0,   0, 0, 0));
    vecs.push_back(mk(1, 1, 32'hB000_0000, 0, 0, 0, 1, 32'h1004, Byp, 32'hB000_0000, 32'h1000, 1));
    vecs.push_back(mk(1, 1, 32'hB000_0001, 0, 0, 0, 1, 32'h1008, 1, 32'hB000_0000, 32'h1000, 2));
    vecs.push_back(mk(1, 1, 32'hB000_0002, 0, 0, 0, 1, 32'h100C, 1, 32'hB000_0000, 32'h1000, 3));
    vecs.push_back(mk(1, 1, 32'hB000_0003, 0, 0, 0, 0, 32'h1010, 1, 32'hB000_0000, 32'h1000, 4));
    vecs.push_back(mk(0, 0, 0,           1, 0, 0, 0, 32'h1010, 1, 32'hB000_0000, 32'h1000, 4));
    vecs.push_back(mk(1, 0, 0,           0, 0, 0, 1, 32'h1010, 1, 32'hB000_0001, 32'h1004, 3));
    vecs.push_back(mk(1, 1, 32'hB000_0004, 0, 0, 0, 0, 32'h1014, 1, 32'hB000_0001, 32'h1004, 4));
    vecs.push_back(mk(1, 0, 0,           0, 0, 0, 0, 32'h1014, 1, 32'hB000_0001, 32'h1004, 4));
    run_vecs();

    // Flush with 3 outstanding to a misaligned target: drain 3 stale responses, resume at 0x100.
    do_reset(32'h0000_2000, "drain");
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h2000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h2004, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h2008, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0,           1, 1, 32'h102, 0, 32'h200C, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 32'h0000_DEAD, 1, 0, 0,      0, 32'h0100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_DEAD, 1, 0, 0,      0, 32'h0100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,           1, 0, 0,      0, 32'h0100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_DEAD, 1, 0, 0,      0, 32'h0100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h0100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0013, 1, 0, 0,      1, 32'h0104, Byp, 32'h13, 32'h100, 1));
    vecs.push_back(mk(0, 0, 0,           1, 0, 0,      1, 32'h0104, !Byp, 32'h13, 32'h100,
                      Byp ? 3'd0 : 3'd1));
    vecs.push_back(mk(0, 0, 0,           1, 0, 0,      1, 32'h0104, 0, 0, 0, 0));
    run_vecs();

    // Flush coinciding with a response, 2 outstanding: only one further response is dropped.
    do_reset(32'h0000_3000, "flrsp");
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h3000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h3004, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h0000_AAAA, 1, 1, 32'h400, 0, 32'h3008, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 32'h0000_BBBB, 1, 0, 0,      0, 32'h0400, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h0400, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_CCCC, 1, 0, 0,      1, 32'h0404, Byp, 32'hCCCC, 32'h400, 1));
    vecs.push_back(mk(0, 0, 0,           1, 0, 0,      1, 32'h0404, !Byp, 32'hCCCC, 32'h400,
                      Byp ? 3'd0 : 3'd1));
    vecs.push_back(mk(0, 0, 0,           1, 0, 0,      1, 32'h0404, 0, 0, 0, 0));
    run_vecs();

    // Flush while already draining: drop count carries over minus the response in that cycle.
    do_reset(32'h0000_5000, "drflush");
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h5000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h5004, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,           1, 1, 32'h600, 0, 32'h5008, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 32'h0000_EEEE, 1, 1, 32'h700, 0, 32'h0600, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      0, 32'h0700, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h0000_EEEF, 1, 0, 0,      0, 32'h0700, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,           1, 0, 0,      1, 32'h0700, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,           1, 0, 0,      1, 32'h0704, 0, 0, 0, 1));
    run_vecs();

    // PC wrap at the top of the address space and single-response decode latency.
    do_reset(32'hFFFF_FFFC, "wrap");
    gnt = 1'b1; dec_ready = 1'b1;
    #1;
    chk("wrap first adr", adr, 32'hFFFF_FFFC);
    chk("wrap first req", 32'(req), 32'd1);
    @(negedge clk);
    gnt = 1'b0;
    #1;
    chk("wrap next adr", adr, 32'h0000_0000);
    chk("wrap occ", 32'(occ), 32'd1);
    @(negedge clk);
    rsp_v = 1'b1; rsp_instr = 32'h0000_0013;
    #1;
    chk("wrap rsp-cycle dec_v", 32'(dec_v), 32'(Byp));
    if (Byp) chk("wrap rsp-cycle instr", instr, 32'h0000_0013);
    @(negedge clk);
    rsp_v = 1'b0;
    #1;
    chk("wrap next-cycle dec_v", 32'(dec_v), 32'(!Byp));
    if (!Byp) begin
      chk("wrap next-cycle instr", instr, 32'h0000_0013);
      chk("wrap next-cycle pc", pc, 32'hFFFF_FFFC);
    end
    @(negedge clk);
    #1;
    chk("wrap final occ", 32'(occ), 32'd0);
    chk("wrap final dec_v", 32'(dec_v), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
